// File: rtl/stream_extreme_finder.sv
// Scans a framed unsigned sample stream and publishes the per-frame extreme
// (max or min, chosen on the SOF beat) together with its first index and the frame length.
module stream_extreme_finder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_eof,
    input  logic [WIDTH-1:0] in_data,
    input  logic             mode_max,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_value,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W-1:0] out_count,
    output logic             busy,
    output logic             restart_err
);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   best_q, best_d;
    logic [IDX_W-1:0]   bestIdx_q, bestIdx_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               modeMax_q, modeMax_d;
    logic               outValid_q, outValid_d;
    logic [WIDTH-1:0]   outValue_q, outValue_d;
    logic [IDX_W-1:0]   outIndex_q, outIndex_d;
    logic [IDX_W-1:0]   outCount_q, outCount_d;
    logic               restartErr_q, restartErr_d;
    logic               better;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            best_q       <= '0;
            bestIdx_q    <= '0;
            cnt_q        <= '0;
            modeMax_q    <= 1'b0;
            outValid_q   <= 1'b0;
            outValue_q   <= '0;
            outIndex_q   <= '0;
            outCount_q   <= '0;
            restartErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            best_q       <= best_d;
            bestIdx_q    <= bestIdx_d;
            cnt_q        <= cnt_d;
            modeMax_q    <= modeMax_d;
            outValid_q   <= outValid_d;
            outValue_q   <= outValue_d;
            outIndex_q   <= outIndex_d;
            outCount_q   <= outCount_d;
            restartErr_q <= restartErr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        best_d       = best_q;
        bestIdx_d    = bestIdx_q;
        cnt_d        = cnt_q;
        modeMax_d    = modeMax_q;
        outValid_d   = 1'b0;
        outValue_d   = outValue_q;
        outIndex_d   = outIndex_q;
        outCount_d   = outCount_q;
        restartErr_d = 1'b0;
        better       = 1'b0;

        if (in_valid) begin
            // An SOF always opens a fresh frame; an SOF arriving into an open frame drops that frame.
            if (in_sof) begin
                restartErr_d = (state_q == ACCUM);
                best_d       = in_data;
                bestIdx_d    = '0;
                cnt_d        = IDX_W'(1);
                modeMax_d    = mode_max;
                state_d      = ACCUM;
            end else if (state_q == ACCUM) begin
                // Strict comparison so that ties keep the earliest index.
                better = modeMax_q ? (in_data > best_q) : (in_data < best_q);
                if (better) begin
                    best_d    = in_data;
                    bestIdx_d = cnt_q;
                end
                cnt_d = cnt_q + IDX_W'(1);
            end

            if (in_eof && (in_sof || state_q == ACCUM)) begin
                state_d    = IDLE;
                outValid_d = 1'b1;
                outValue_d = best_d;
                outIndex_d = bestIdx_d;
                outCount_d = cnt_d;
            end
        end
    end

    assign out_valid   = outValid_q;
    assign out_value   = outValue_q;
    assign out_index   = outIndex_q;
    assign out_count   = outCount_q;
    assign restart_err = restartErr_q;
    assign busy        = (state_q == ACCUM);

endmodule

// File: doc/stream_extreme_finder.md
Name: stream_extreme_finder

Overview:
- Parametrised successor to the single-cycle 8-bit greater-than leaf comparator.
- Scans a framed pixel stream and reports the extreme value (max or min, selectable per frame) plus its index and the frame length.
- Used for atmospheric-light estimation (max of dark channel) and for min reductions in the dark-channel path.
- Sits between the dark-channel stage and the transmission-estimation control.

Parameters:
- WIDTH, 8, pixel/data width in bits
- IDX_W, 16, width of index and count outputs; counters wrap modulo 2^IDX_W

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  in_data/in_sof/in_eof qualified this cycle
- in_sof  input  1  first beat of frame (valid only with in_valid)
- in_eof  input  1  last beat of frame (valid only with in_valid)
- in_data  input  WIDTH  sample, unsigned
- mode_max  input  1  1 = find maximum, 0 = find minimum; sampled on SOF beat only
- out_valid  output  1  one-cycle pulse: result registers valid
- out_value  output  WIDTH  extreme value of last completed frame
- out_index  output  IDX_W  beat index (0-based) of the extreme within the frame
- out_count  output  IDX_W  number of beats in the frame (mod 2^IDX_W)
- busy  output  1  high while in ACCUM state
- restart_err  output  1  one-cycle pulse: SOF arrived while a frame was open

Behaviour:
- Reset: all outputs 0; state IDLE; internal accumulator/index/counter 0; latched mode 0.
- States: IDLE, ACCUM.
- IDLE, in_valid & in_sof:
  - best <= in_data, best_idx <= 0, cnt <= 1, mode latched from mode_max.
  - Go to ACCUM unless in_eof is also set (see single-beat frames).
- IDLE, in_valid without in_sof: beat ignored, no state change.
- ACCUM, in_valid & !in_sof:
  - Candidate replaces best when strictly better: max mode in_data > best; min mode in_data < best.
  - Ties keep the earlier index (first occurrence wins).
  - On replace: best_idx <= cnt. In every case cnt <= cnt+1, wrapping.
- ACCUM, in_valid & in_eof: the beat is included in the comparison, then go to IDLE and publish.
- Publish:
  - On the cycle after the EOF beat: out_valid = 1 for exactly one cycle.
  - out_value/out_index/out_count hold the final values, which include the EOF beat.
  - Result registers hold until the next publish or reset.
  - Latency from EOF beat to out_valid is 1 clock.
- Single-beat frame (in_sof & in_eof on the same beat, from IDLE or ACCUM):
  - Publish value = in_data, index 0, count 1.
  - State ends in IDLE.
- SOF while in ACCUM:
  - restart_err pulses the next cycle.
  - The open frame is discarded (no publish) and a new frame starts from this beat as in IDLE.
- in_valid low: no state or counter change; gaps are allowed anywhere in a frame.
- in_sof/in_eof without in_valid: ignored.
- mode_max changes mid-frame: ignored until the next SOF.
- Index/count wrap: past 2^IDX_W-1 they roll to 0. Comparisons continue; out_count reports the frame length modulo 2^IDX_W.
- rst mid-frame: frame abandoned, no out_valid, no restart_err, outputs cleared next cycle.
- rst has priority over all inputs in the same cycle.
- busy = (state == ACCUM), registered.
- Comparison is purely unsigned, WIDTH bits. There is no combinational path from inputs to outputs.

Test Plan:
- Max, 5 beats, mode_max=1, data 10,200,55,200,3 (SOF on 10, EOF on 3) -> out_valid one cycle after EOF; value 200, index 1 (tie keeps first), count 5.
- Min, same data, mode_max=0 -> value 3, index 4, count 5. Toggling mode_max mid-frame leaves the result unchanged.
- Single beat: in_sof=in_eof=1, data 0x7F -> next cycle out_valid; value 0x7F, index 0, count 1; busy stays 0.
- Gaps and ignored beats:
  - Valid beats before any SOF are ignored.
  - Frame 1,9,4 with 2 idle cycles between beats -> value 9, index 1, count 3.
- Restart: SOF, 250, 240, then SOF 5, 6, EOF 7 (max) -> restart_err pulse after the second SOF; a single publish with value 7, index 2, count 3.
- Reset mid-frame: rst asserted after 3 beats, then a fresh frame 4,8 -> no out_valid from the aborted frame; next publish value 8, index 1, count 2.
- Optional: IDX_W=3 bench with a 10-beat frame -> count reports 2 (wrap).
